dist_relaxer: RTL and testbench

//  Requester side of the DistanceStore get/set protocol: relaxes all outgoing edges of one settled node.
//  For each node v it reads dist[v] from the store and compares it with dist[u] + w(u,v).
//  If the new path is shorter, it writes the improved distance back to the store.

---
 rtl/dist_relaxer_pkg.sv | 17 +
 rtl/dist_relaxer_sat_add.sv | 16 +
 rtl/dist_relaxer.sv | 105 ++++++++++
 tb/tb_dist_relaxer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dist_relaxer_pkg.sv
// Shared types and defaults for the distance relaxer: FSM state encoding and
// default sizing. A value of all ones means "infinite distance / no edge".
package dist_relaxer_pkg;

  localparam int DEFAULT_MAX_NODES   = 4;
  localparam int DEFAULT_INDEX_WIDTH = 2;
  localparam int DEFAULT_VALUE_WIDTH = 8;

  typedef enum logic [2:0] {
    RLX_IDLE    = 3'd0,
    RLX_READ    = 3'd1,
    RLX_COMPARE = 3'd2,
    RLX_WRITE   = 3'd3,
    RLX_DONE    = 3'd4
  } rlx_state_e;

endpackage

// File: rtl/dist_relaxer_sat_add.sv
// Saturating unsigned adder: all-ones (infinity) is absorbing, and any carry-out
// clamps to infinity so a path can never wrap around to look short.
module dist_relaxer_sat_add #(
  parameter int VALUE_WIDTH = 8
) (
  input  logic [VALUE_WIDTH-1:0] i_a,
  input  logic [VALUE_WIDTH-1:0] i_b,
  output logic [VALUE_WIDTH-1:0] o_sum
);

  logic [VALUE_WIDTH:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum  = (&i_a || &i_b || w_full[VALUE_WIDTH]) ? '1 : w_full[VALUE_WIDTH-1:0];

endmodule

// File: rtl/dist_relaxer.sv
// Relaxes every outgoing edge of one settled node u: reads dist[v] from the
// store, and writes dist[u]+w(u,v) back when it is strictly shorter.
module dist_relaxer
  import dist_relaxer_pkg::*;
#(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] src_index,
  input  logic [VALUE_WIDTH-1:0] src_dist,
  output logic [INDEX_WIDTH-1:0] weight_index,
  input  logic [VALUE_WIDTH-1:0] weight_in,
  output logic                   get_en,
  output logic                   set_en,
  output logic [INDEX_WIDTH-1:0] index,
  inout  wire  [VALUE_WIDTH-1:0] value,
  output logic                   busy,
  output logic                   done,
  output logic [INDEX_WIDTH:0]   update_count
);

  rlx_state_e             r_state, w_next;
  logic [INDEX_WIDTH-1:0] r_u, r_v;
  logic [VALUE_WIDTH-1:0] r_du, r_dv, r_sum, w_sum;
  logic [INDEX_WIDTH:0]   r_cnt;
  logic                   r_busy, r_done;
  logic                   w_skip, w_last, w_better, w_advance;

  dist_relaxer_sat_add #(.VALUE_WIDTH(VALUE_WIDTH)) u_add (
    .i_a   (r_du),
    .i_b   (weight_in),
    .o_sum (w_sum)
  );

  assign w_skip   = (r_v == r_u) || (&weight_in);
  assign w_last   = (r_v == INDEX_WIDTH'(MAX_NODES - 1));
  assign w_better = (r_sum < r_dv);

  // Strobes decode straight from state so an async reset drops them at once.
  assign get_en = (r_state == RLX_READ) && !w_skip;
  assign set_en = (r_state == RLX_WRITE);
  assign value  = set_en ? r_sum : 'z;

  assign index        = r_v;
  assign weight_index = r_v;
  assign busy         = r_busy;
  assign done         = r_done;
  assign update_count = r_cnt;

  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    case (r_state)
      RLX_IDLE:    if (start) w_next = RLX_READ;
      RLX_READ:    if (w_skip) w_advance = 1'b1; else w_next = RLX_COMPARE;
      RLX_COMPARE: if (w_better) w_next = RLX_WRITE; else w_advance = 1'b1;
      RLX_WRITE:   w_advance = 1'b1;
      RLX_DONE:    w_next = RLX_IDLE;
      default:     w_next = RLX_IDLE;
    endcase
    if (w_advance) w_next = w_last ? RLX_DONE : RLX_READ;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RLX_IDLE;
      r_u     <= '0;
      r_v     <= '0;
      r_du    <= '0;
      r_dv    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (r_state == RLX_IDLE && start) begin
        r_u    <= src_index;
        r_du   <= src_dist;
        r_v    <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
      if (get_en) begin
        r_dv  <= value;
        r_sum <= w_sum;
      end
      if (set_en) r_cnt <= r_cnt + 1'b1;
      if (w_advance) begin
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_v <= r_v + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dist_relaxer.sv
// Scoreboard bench for dist_relaxer: stimulus queues expected writes and pass
// results, a negedge monitor pops and compares them as the DUT presents them.
module tb_dist_relaxer;

  localparam int NN = 4;
  localparam int IW = 2;
  localparam int VW = 8;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [VW-1:0] val;
  } wr_t;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] src_index = '0;
  logic [VW-1:0] src_dist = '0;
  logic [IW-1:0] weight_index;
  logic [VW-1:0] weight_in;
  logic          get_en, set_en, busy, done;
  logic [IW-1:0] index;
  logic [IW:0]   update_count;
  wire  [VW-1:0] value;

  logic [VW-1:0] mem [NN];
  logic [VW-1:0] wt  [NN];

  wr_t wr_q[$];
  int  cnt_q[$];
  int  lat_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  t_start = 0;

  dist_relaxer #(.MAX_NODES(NN), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
    .clock        (clock),
    .reset        (rst_n),
    .start        (start),
    .src_index    (src_index),
    .src_dist     (src_dist),
    .weight_index (weight_index),
    .weight_in    (weight_in),
    .get_en       (get_en),
    .set_en       (set_en),
    .index        (index),
    .value        (value),
    .busy         (busy),
    .done         (done),
    .update_count (update_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural store and weight memory.
  assign value     = get_en ? mem[index] : 8'bz;
  assign weight_in = wt[weight_index];
  always @(posedge clock) if (rst_n && set_en) mem[index] <= value;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (rst_n) begin
      check("get_set_exclusive", {31'd0, get_en & set_en}, 32'd0);
      if (get_en) check("store_read_value", {24'd0, value}, {24'd0, mem[index]});
      if (set_en) begin
        if (wr_q.size() == 0) check("unexpected_write", {22'd0, index, value}, 32'd0);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          check("write_index", {30'd0, index}, {30'd0, e.idx});
          check("write_value", {24'd0, value}, {24'd0, e.val});
        end
      end
      if (done) begin
        if (cnt_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          check("update_count", {29'd0, update_count}, cnt_q.pop_front());
          check("pass_latency", cyc - t_start, lat_q.pop_front());
          check("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic load(input logic [31:0] m, input logic [31:0] w);
    for (int i = 0; i < NN; i++) begin
      mem[i] = m[8*(NN-1-i) +: 8];
      wt[i]  = w[8*(NN-1-i) +: 8];
    end
  endtask

  task automatic kick(input logic [IW-1:0] u, input logic [VW-1:0] du);
    @(negedge clock);
    src_index = u;
    src_dist  = du;
    start     = 1'b1;
    t_start   = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    load(32'h00FF04FF, 32'hFF02FF07);
    repeat (3) @(negedge clock);
    check("rst_get_en", {31'd0, get_en}, 32'd0);
    check("rst_set_en", {31'd0, set_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_index", {30'd0, index}, 32'd0);
    check("rst_weight_index", {30'd0, weight_index}, 32'd0);
    check("rst_update_count", {29'd0, update_count}, 32'd0);
    rst_n = 1'b1;

    // Basic: v1 and v3 improved from infinity, v0 is the source, v2 has no edge.
    wr_q.push_back('{2'd1, 8'd5});
    wr_q.push_back('{2'd3, 8'd10});
    cnt_q.push_back(2); lat_q.push_back(9);
    kick(2'd0, 8'd3);
    wait_done();
    @(negedge clock);
    check("t1_mem1", {24'd0, mem[1]}, 32'd5);
    check("t1_mem2", {24'd0, mem[2]}, 32'd4);
    check("t1_mem3", {24'd0, mem[3]}, 32'd10);
    check("t1_count_held", {29'd0, update_count}, 32'd2);

    // No improvement incl. an equal sum; a start during the pass is ignored.
    load(32'h00050602, 32'h01FF0101);
    cnt_q.push_back(0); lat_q.push_back(8);
    kick(2'd1, 8'd5);
    @(negedge clock);
    src_index = 2'd0; src_dist = 8'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();
    @(negedge clock);
    check("t2_mem2", {24'd0, mem[2]}, 32'd6);

    // Saturation: 0xF0+0x20 clamps to infinity, which never beats infinity.
    load(32'h00FFFFFF, 32'hFFFF20FF);
    cnt_q.push_back(0); lat_q.push_back(6);
    kick(2'd0, 8'hF0);
    wait_done();
    @(negedge clock);
    check("t3_mem2", {24'd0, mem[2]}, 32'hFF);

    // Infinite source distance: no writes whatever the weights.
    load(32'h00FF07FF, 32'h01010101);
    cnt_q.push_back(0); lat_q.push_back(8);
    kick(2'd0, 8'hFF);
    wait_done();
    @(negedge clock);
    check("t3b_count", {29'd0, update_count}, 32'd0);

    // Async reset in the middle of the first WRITE cycle.
    load(32'h00FF04FF, 32'hFF02FF07);
    kick(2'd0, 8'd3);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        @(posedge clock); #2;
        if (set_en) hit = 1'b1;
      end
      check("t5_reached_write", {31'd0, hit}, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("t5_set_en", {31'd0, set_en}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_get_en", {31'd0, get_en}, 32'd0);
    check("t5_count", {29'd0, update_count}, 32'd0);
    @(negedge clock);
    check("t5_mem1_kept", {24'd0, mem[1]}, 32'hFF);
    rst_n = 1'b1;

    // Clean pass after the abort.
    wr_q.push_back('{2'd1, 8'd5});
    wr_q.push_back('{2'd3, 8'd10});
    cnt_q.push_back(2); lat_q.push_back(9);
    kick(2'd0, 8'd3);
    wait_done();
    @(negedge clock);
    check("t5_mem3", {24'd0, mem[3]}, 32'd10);
    check("writes_drained", wr_q.size(), 32'd0);
    check("passes_drained", cnt_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
